// File: rtl/tropang_pkg.sv
`default_nettype none
// ============================================================================
//  tropang_pkg : shared types and default constants for the Tropical Angel
//  ROM loader.                                               Rev 1.0
// ============================================================================
package tropang_pkg;

    localparam int ADDR_W     = 25;
    localparam int BYTE_CNT_W = 17;

    localparam logic [ADDR_W-1:0] MAIN_END_DEF  = 25'h08000;
    localparam logic [ADDR_W-1:0] SND_END_DEF   = 25'h0A000;
    localparam logic [ADDR_W-1:0] GFX_END_DEF   = 25'h1E000;
    localparam logic [ADDR_W-1:0] PROM_END_DEF  = 25'h1E400;
    localparam int                SETTLE_DEF    = 256;
    localparam logic [7:0]        ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0]        DIP_INDEX_DEF = 8'd254;

    typedef enum logic [1:0] {
        REG_MAIN = 2'd0,
        REG_SND  = 2'd1,
        REG_GFX  = 2'd2,
        REG_PROM = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    function automatic logic [3:0] region_onehot(input region_e r);
        return 4'b0001 << r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  rom_region_decode : maps a download byte address to its ROM region,
//  region-relative address and an out-of-range flag.         Rev 1.0
// ============================================================================
module rom_region_decode
    import tropang_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAIN_END = MAIN_END_DEF,
    parameter logic [ADDR_W-1:0] SND_END  = SND_END_DEF,
    parameter logic [ADDR_W-1:0] GFX_END  = GFX_END_DEF,
    parameter logic [ADDR_W-1:0] PROM_END = PROM_END_DEF
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [3:0]        hit_o,
    output logic [ADDR_W-1:0] rel_addr_o,
    output logic              oor_o
);

    region_e            region_d;
    logic [ADDR_W-1:0]  base_d;

    always_comb begin
        region_d = REG_MAIN;
        base_d   = '0;
        oor_o    = 1'b0;
        if (addr_i < MAIN_END) begin
            region_d = REG_MAIN;
            base_d   = '0;
        end else if (addr_i < SND_END) begin
            region_d = REG_SND;
            base_d   = MAIN_END;
        end else if (addr_i < GFX_END) begin
            region_d = REG_GFX;
            base_d   = SND_END;
        end else if (addr_i < PROM_END) begin
            region_d = REG_PROM;
            base_d   = GFX_END;
        end else begin
            oor_o    = 1'b1;
        end
        hit_o      = oor_o ? 4'b0000 : region_onehot(region_d);
        rel_addr_o = oor_o ? '0 : (addr_i - base_d);
    end

endmodule
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
//  rom_load_ctrl : steers the ioctl download stream into ROM regions, latches
//  the DIP bank and sequences the game-core reset.           Rev 1.0
// ============================================================================
module rom_load_ctrl
    import tropang_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAIN_END      = MAIN_END_DEF,
    parameter logic [ADDR_W-1:0] SND_END       = SND_END_DEF,
    parameter logic [ADDR_W-1:0] GFX_END       = GFX_END_DEF,
    parameter logic [ADDR_W-1:0] PROM_END      = PROM_END_DEF,
    parameter int                SETTLE_CYCLES = SETTLE_DEF,
    parameter logic [7:0]        ROM_INDEX     = ROM_INDEX_DEF,
    parameter logic [7:0]        DIP_INDEX     = DIP_INDEX_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ext_reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic [3:0]        rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic [63:0]       dip_sw,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_error
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [BYTE_CNT_W-1:0] TOTAL_BYTES = PROM_END[BYTE_CNT_W-1:0];

    state_e                  state_q;
    logic [SETTLE_W-1:0]     settle_q;
    logic [BYTE_CNT_W-1:0]   bytes_q;
    logic                    done_q;
    logic                    err_q;
    logic                    core_rst_n_q;
    logic [3:0]              rom_we_q;
    logic [ADDR_W-1:0]       rom_addr_q;
    logic [7:0]              rom_data_q;
    logic [63:0]             dip_q;

    logic [3:0]              dec_hit;
    logic [ADDR_W-1:0]       dec_rel;
    logic                    dec_oor;

    logic                    rom_acc_d;
    logic                    dip_acc_d;
    logic                    load_entry_d;
    logic [BYTE_CNT_W-1:0]   bytes_base_d;
    logic [BYTE_CNT_W-1:0]   bytes_d;
    logic                    err_d;
    logic                    err_exit_d;

    rom_region_decode #(
        .MAIN_END (MAIN_END),
        .SND_END  (SND_END),
        .GFX_END  (GFX_END),
        .PROM_END (PROM_END)
    ) u_decode (
        .addr_i     (ioctl_addr),
        .hit_o      (dec_hit),
        .rel_addr_o (dec_rel),
        .oor_o      (dec_oor)
    );

    // Entry clears the counter and error in the same cycle a first byte may
    // arrive, so the first byte is folded onto the cleared base.
    always_comb begin
        rom_acc_d    = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
        dip_acc_d    = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[ADDR_W-1:3] == '0);
        load_entry_d = ioctl_download && (ioctl_index == ROM_INDEX) && (state_q != ST_LOAD);
        bytes_base_d = load_entry_d ? '0 : bytes_q;
        bytes_d      = bytes_base_d;
        if (rom_acc_d && !dec_oor && (bytes_base_d != '1)) begin
            bytes_d = bytes_base_d + 1'b1;
        end
        err_d        = (load_entry_d ? 1'b0 : err_q) | (rom_acc_d && dec_oor);
        err_exit_d   = err_q | (bytes_q != TOTAL_BYTES);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_we_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            dip_q      <= '0;
        end else begin
            rom_we_q <= '0;
            if (rom_acc_d && !dec_oor) begin
                rom_we_q   <= dec_hit;
                rom_addr_q <= dec_rel;
                rom_data_q <= ioctl_dout;
            end
            if (dip_acc_d) begin
                dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HOLD;
            settle_q     <= '0;
            bytes_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        // An errored set still runs; the error is only flagged.
                        state_q  <= ST_SETTLE;
                        settle_q <= '0;
                        err_q    <= err_exit_d;
                        done_q   <= !err_exit_d;
                    end else begin
                        bytes_q  <= bytes_d;
                        err_q    <= err_d;
                    end
                end
                default: begin
                    if (load_entry_d) begin
                        state_q      <= ST_LOAD;
                        bytes_q      <= bytes_d;
                        err_q        <= err_d;
                        done_q       <= 1'b0;
                        core_rst_n_q <= 1'b0;
                    end else if (state_q == ST_SETTLE) begin
                        if (ext_reset) begin
                            settle_q <= '0;
                        end else if (settle_q == SETTLE_LAST) begin
                            state_q      <= ST_RUN;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end else if ((state_q == ST_RUN) && ext_reset) begin
                        state_q      <= ST_SETTLE;
                        settle_q     <= '0;
                        core_rst_n_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_data     = rom_data_q;
    assign dip_sw       = dip_q;
    assign core_reset_n = core_rst_n_q;
    assign load_done    = done_q;
    assign load_error   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_rom_load_ctrl : directed self-checking bench for rom_load_ctrl with
//  scaled-down region boundaries and the default settle interval. Rev 1.0
// ============================================================================
module tb_rom_load_ctrl;

    localparam logic [24:0] T_MAIN   = 25'h00080;
    localparam logic [24:0] T_SND    = 25'h000A0;
    localparam logic [24:0] T_GFX    = 25'h001E0;
    localparam logic [24:0] T_PROM   = 25'h001E4;
    localparam int          T_SETTLE = 256;

    logic        clk_sys        = 1'b0;
    logic        reset_n        = 1'b0;
    logic        ext_reset      = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
    logic [7:0]  ioctl_index    = '0;
    logic [3:0]  rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [63:0] dip_sw;
    logic        core_reset_n;
    logic        load_done;
    logic        load_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    rom_load_ctrl #(
        .MAIN_END      (T_MAIN),
        .SND_END       (T_SND),
        .GFX_END       (T_GFX),
        .PROM_END      (T_PROM),
        .SETTLE_CYCLES (T_SETTLE),
        .ROM_INDEX     (8'd0),
        .DIP_INDEX     (8'd254)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ext_reset      (ext_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .dip_sw         (dip_sw),
        .core_reset_n   (core_reset_n),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int a);
        logic [31:0] t;
        t = a;
        return t[7:0] ^ 8'h5A;
    endfunction

    task automatic check_strobe(input int a);
        logic [3:0] we;
        int         base;
        if (a < 'h80)       begin we = 4'b0001; base = 0;     end
        else if (a < 'hA0)  begin we = 4'b0010; base = 'h80;  end
        else if (a < 'h1E0) begin we = 4'b0100; base = 'hA0;  end
        else                begin we = 4'b1000; base = 'h1E0; end
        check_val($sformatf("rom_we@%0h", a),   64'(rom_we),   64'(we));
        check_val($sformatf("rom_addr@%0h", a), 64'(rom_addr), 64'(a - base));
        check_val($sformatf("rom_data@%0h", a), 64'(rom_data), 64'(byte_of(a)));
    endtask

    // Bytes 0..n_bytes-1 back to back; the first strobe coincides with the
    // download rising. Leaves ioctl_download low at a falling clock edge.
    task automatic rom_load(input int n_bytes, input bit oor_tail);
        for (int i = 0; i < n_bytes; i++) begin
            @(negedge clk_sys);
            if (i > 0) check_strobe(i - 1);
            if (i == 1) check_val("core_rst_after_entry", 64'(core_reset_n), 64'd0);
            ioctl_index    = 8'd0;
            ioctl_download = 1'b1;
            ioctl_wr       = 1'b1;
            ioctl_addr     = 25'(i);
            ioctl_dout     = byte_of(i);
        end
        @(negedge clk_sys);
        check_strobe(n_bytes - 1);
        if (oor_tail) begin
            ioctl_addr = T_PROM;
            ioctl_dout = 8'hEE;
            @(negedge clk_sys);
            check_val("oor_no_strobe", 64'(rom_we), 64'd0);
            check_val("oor_err_now", 64'(load_error), 64'd1);
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic wait_release(input string tag, input int start_n);
        int n;
        n = start_n;
        do begin
            @(negedge clk_sys);
            n++;
        end while (core_reset_n !== 1'b1 && n < 2000);
        check_val(tag, 64'(n), 64'(T_SETTLE + 1));
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_we"},   64'(rom_we),       64'd0);
        check_val({tag, "_addr"}, 64'(rom_addr),     64'd0);
        check_val({tag, "_data"}, 64'(rom_data),     64'd0);
        check_val({tag, "_dip"},  dip_sw,            64'd0);
        check_val({tag, "_core"}, 64'(core_reset_n), 64'd0);
        check_val({tag, "_done"}, 64'(load_done),    64'd0);
        check_val({tag, "_err"},  64'(load_error),   64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_reset_values("rst");
        repeat (10) @(negedge clk_sys);
        check_val("hold_core", 64'(core_reset_n), 64'd0);

        rom_load(int'(T_PROM), 1'b0);
        wait_release("full_release", 0);
        check_val("full_done", 64'(load_done),  64'd1);
        check_val("full_err",  64'(load_error), 64'd0);

        for (int k = 0; k < 8; k++) begin
            @(negedge clk_sys);
            ioctl_index    = 8'd254;
            ioctl_download = 1'b1;
            ioctl_wr       = 1'b1;
            ioctl_addr     = 25'(k);
            ioctl_dout     = 8'(8'h11 * (k + 1));
        end
        @(negedge clk_sys);
        ioctl_addr = 25'h8;
        ioctl_dout = 8'hFF;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        @(negedge clk_sys);
        check_val("dip_bank", dip_sw, 64'h8877665544332211);
        check_val("dip_core", 64'(core_reset_n), 64'd1);

        ext_reset = 1'b1;
        @(negedge clk_sys);
        ext_reset = 1'b0;
        check_val("ext_core_low", 64'(core_reset_n), 64'd0);
        repeat (99) @(negedge clk_sys);
        check_val("ext_still_low", 64'(core_reset_n), 64'd0);
        ext_reset = 1'b1;
        @(negedge clk_sys);
        ext_reset = 1'b0;
        wait_release("ext_release", 1);

        rom_load(int'(T_PROM) - 1, 1'b0);
        wait_release("short_release", 0);
        check_val("short_err",  64'(load_error), 64'd1);
        check_val("short_done", 64'(load_done),  64'd0);

        rom_load(int'(T_PROM), 1'b1);
        wait_release("oor_release", 0);
        check_val("oor_err", 64'(load_error), 64'd1);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            ioctl_index    = 8'd0;
            ioctl_download = 1'b1;
            ioctl_wr       = 1'b1;
            ioctl_addr     = 25'(i);
            ioctl_dout     = byte_of(i);
        end
        @(negedge clk_sys);
        reset_n        = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        check_reset_values("midrst");
        repeat (300) @(negedge clk_sys);
        check_val("midrst_hold_core", 64'(core_reset_n), 64'd0);
        check_val("midrst_hold_done", 64'(load_done),    64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequences the HPS ioctl download stream for the Tropical Angel core. It steers ROM bytes into four ROM/PROM regions with region-relative addresses and latches the 8-byte DIP bank. It holds the game core in reset until a complete ROM set has loaded and a settle interval has expired. It sits between `hps_io` and the CPU/video/sound ROM instances in `emu`, and replaces ad-hoc decoding in the top level.

## Interface
Parameters:
- `MAIN_END`, 25'h08000: exclusive end of main CPU ROM region (region 0 starts at 0).
- `SND_END`, 25'h0A000: exclusive end of sound CPU ROM (region 1).
- `GFX_END`, 25'h1E000: exclusive end of tile/sprite ROMs (region 2).
- `PROM_END`, 25'h1E400: exclusive end of colour PROMs (region 3). This is also the required total byte count.
- `SETTLE_CYCLES`, 256: number of `clk_sys` cycles of core reset after a load or external reset; minimum 1.
- `ROM_INDEX`, 0: ioctl index for the ROM set.
- `DIP_INDEX`, 254: ioctl index for the DIP bank.

Ports:
- `clk_sys`  in  1: sole clock.
- `reset_n`  in  1: reset, asynchronous assert, active low.
- `ext_reset`  in  1: synchronous, active high. Driven by OSD reset, user button and RESET.
- `ioctl_download`  in  1: download window.
- `ioctl_wr`  in  1: one-cycle byte strobe.
- `ioctl_addr`  in  25: byte address within the current index.
- `ioctl_dout`  in  8: byte data.
- `ioctl_index`  in  8: download index.
- `rom_we`  out  4: one-hot region write strobe.
- `rom_addr`  out  25: address relative to the start of the region.
- `rom_data`  out  8: write data.
- `dip_sw`  out  64: DIP bank. Byte *k* is at bits [8k+7:8k].
- `core_reset_n`  out  1: active-low reset to the game core.
- `load_done`  out  1: the last ROM load completed without error.
- `load_error`  out  1: sticky error for the current load.

## Operation
- States:
  - HOLD: the state after reset; no ROM has been loaded yet.
  - LOAD
  - SETTLE
  - RUN
- `core_reset_n` = 1 only in RUN.
- Transitions:
  - HOLD/SETTLE/RUN → LOAD: `ioctl_download && ioctl_index==ROM_INDEX`.
  - LOAD → SETTLE: `ioctl_download` falls. This happens regardless of `load_error`, because an errored set still runs; the error is only flagged.
  - SETTLE → RUN: the settle counter reaches `SETTLE_CYCLES-1`.
  - RUN → SETTLE: `ext_reset`. `ext_reset` in SETTLE reloads the counter. `ext_reset` in HOLD or LOAD is ignored.
- Entering LOAD clears `load_done`, `load_error` and the byte counter.
- ROM write: a write is accepted when `ioctl_wr && ioctl_download && ioctl_index==ROM_INDEX`.
  - The region is the lowest *r* with `ioctl_addr < END_r`.
  - The region start is subtracted from the address to form `rom_addr`.
  - The 17-bit byte counter is incremented.
- Address ≥ `PROM_END`: the byte is dropped (no strobe) and `load_error` is set.
- On leaving LOAD:
  - `load_error` is set if counter ≠ `PROM_END`.
  - Otherwise `load_done` is set.
- DIP write: when `ioctl_wr && ioctl_index==DIP_INDEX && ioctl_addr[24:3]==0`, the write stores byte `ioctl_addr[2:0]`.
  - DIP writes are accepted in any state and never affect state or `core_reset_n`.
- Writes with any other index are ignored.
- Reset values:
  - state HOLD
  - `rom_we`=0, `rom_addr`=0, `rom_data`=0, `dip_sw`=0
  - `core_reset_n`=0, `load_done`=0, `load_error`=0
- `reset_n` asserted mid-load aborts the load immediately. The host must re-download.

## Timing
- `rom_we`, `rom_addr` and `rom_data` are registered: valid exactly 1 cycle after the accepted `ioctl_wr`, and `rom_we` is high for 1 cycle.
- `dip_sw` updates 1 cycle after the strobe.
- A write in the same cycle that `ioctl_download` rises is accepted: decode does not wait for the LOAD state.
- A write in the same cycle that `ioctl_download` falls is rejected.
- `core_reset_n` rises exactly `SETTLE_CYCLES`+1 cycles after `ioctl_download` falls, or after `ext_reset` in RUN.
- `core_reset_n` falls 1 cycle after the LOAD entry condition or `ext_reset`.
- Back-to-back `ioctl_wr` on consecutive cycles must be supported with no bubbles.

## Structure
- Package `tropang_pkg`:
  - Region enum: REG_MAIN, REG_SND, REG_GFX, REG_PROM.
  - State enum.
  - Default boundary constants and the `ROM_INDEX`/`DIP_INDEX` constants.
- Sub-module `rom_region_decode` (combinational): address → {hit one-hot, relative address, out-of-range}.
- The FSM, counters and output registers live in `rom_load_ctrl`.

## Test plan
- Full ROM download, 0..0x1E3FF, one byte per cycle:
  - strobes land in regions 0/1/2/3 with relative addresses 0..0x7FFF, 0..0x1FFF, 0..0x13FFF, 0..0x3FF;
  - `load_done`=1, `load_error`=0;
  - `core_reset_n` rises 257 cycles after the download ends.
- Short download ending at 0x1E3FE: `load_error`=1, `load_done`=0, and the core is released after settle.
- Write at 0x1E400: no `rom_we`, `load_error`=1.
- DIP download of 8 bytes 0x11..0x88 while in RUN: `dip_sw`=64'h8877665544332211 and `core_reset_n` stays 1.
- `ext_reset` pulse in RUN: `core_reset_n`=0 next cycle. A second pulse 100 cycles later restarts the count, so release comes 257 cycles after the second pulse.
- `reset_n` low for 1 cycle mid-load: all outputs go to reset values, the state is HOLD, and `core_reset_n` stays 0 with no further download.
